// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU
// function codes, step states, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam int FLD_W = 4;

  // Opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU function codes
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_ROR  = 5'b00111;
  localparam logic [4:0] ALU_ROL  = 5'b01000;
  localparam logic [4:0] ALU_SHR  = 5'b01001;
  localparam logic [4:0] ALU_SHRA = 5'b01010;
  localparam logic [4:0] ALU_SHL  = 5'b01011;
  localparam logic [4:0] ALU_DIV  = 5'b01111;
  localparam logic [4:0] ALU_MUL  = 5'b10000;
  localparam logic [4:0] ALU_NEG  = 5'b10001;
  localparam logic [4:0] ALU_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } step_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_IMM, CLS_UN, CLS_MD, CLS_LD, CLS_ST,
    CLS_MFHI, CLS_MFLO, CLS_HALT
  } cls_e;

  typedef struct packed {
    logic       pc_in;
    logic       ir_in;
    logic       y_in;
    logic       zhi_in;
    logic       zlo_in;
    logic       hi_in;
    logic       lo_in;
    logic       mdr_in;
    logic       mar_in;
    logic       inc_pc;
    logic       pc_out;
    logic       zlo_out;
    logic       zhi_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       c_out;
    logic       read;
    logic       write;
    logic [4:0] alu_op;
  } ctl_t;

  // Execute-sequence family of an opcode; anything unlisted runs as nop.
  function automatic cls_e op_class(input logic [4:0] op);
    cls_e c;
    c = CLS_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:             c = CLS_ALU;
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:    c = CLS_IMM;
      OP_NEG, OP_NOT:                      c = CLS_UN;
      OP_MUL, OP_DIV:                      c = CLS_MD;
      OP_LD:                               c = CLS_LD;
      OP_ST:                               c = CLS_ST;
      OP_MFHI:                             c = CLS_MFHI;
      OP_MFLO:                             c = CLS_MFLO;
      OP_HALT:                             c = CLS_HALT;
      OP_NOP:                              c = CLS_NOP;
      default:                             c = CLS_NOP;
    endcase
    return c;
  endfunction

  // ALU function used by an opcode's compute step (address math uses ADD).
  function automatic logic [4:0] op_alu(input logic [4:0] op);
    logic [4:0] a;
    a = ALU_ADD;
    case (op)
      OP_SUB:                         a = ALU_SUB;
      OP_AND, OP_ANDI:                a = ALU_AND;
      OP_OR, OP_ORI:                  a = ALU_OR;
      OP_ROR:                         a = ALU_ROR;
      OP_ROL:                         a = ALU_ROL;
      OP_SHR:                         a = ALU_SHR;
      OP_SHRA:                        a = ALU_SHRA;
      OP_SHL:                         a = ALU_SHL;
      OP_DIV:                         a = ALU_DIV;
      OP_MUL:                         a = ALU_MUL;
      OP_NEG:                         a = ALU_NEG;
      OP_NOT:                         a = ALU_NOT;
      default:                        a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Register field decoder: 4-bit register number plus enable -> one-hot
// select across NREG general registers (all zero when disabled).
module reg_field_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic [FLD_W-1:0] fld_i,
  input  logic             en_i,
  output logic [NREG-1:0]  sel_o
);

  // One comparator per register; out-of-range fields select nothing.
  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_o[i] = en_i && (fld_i == FLD_W'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the bus-based CPU datapath. Steps T0..T7
// per instruction (fetch, then a per-class execute sequence) and drives
// every datapath strobe as a Moore function of (step, decoded ir).
// Optional feature macro CU_MEM_WAIT_EN: memory steps stall on mem_ready
// with a WAIT_MAX timeout that halts and raises a sticky fault.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int OPC_W    = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            pc_in,
  output logic            ir_in,
  output logic            y_in,
  output logic            zhi_in,
  output logic            zlo_in,
  output logic            hi_in,
  output logic            lo_in,
  output logic            mdr_in,
  output logic            mar_in,
  output logic            inc_pc,
  output logic            pc_out,
  output logic            zlo_out,
  output logic            zhi_out,
  output logic            mdr_out,
  output logic            hi_out,
  output logic            lo_out,
  output logic            c_out,
  output logic            read,
  output logic            write,
  output logic [4:0]      alu_op,
  output logic            run,
  output logic            fault
);

  step_e             state_q, state_d;
  logic              run_q;
  ctl_t              ctl;
  logic              rin_en, rout_en;
  logic [FLD_W-1:0]  rout_fld;
  logic [OPC_W-1:0]  op;
  logic [FLD_W-1:0]  ra, rb, rc;
  cls_e              cls;
  logic [4:0]        alu;
  logic              mem_go;
  logic              timeout;
  logic              unused_ir;

  assign op  = ir[31 -: OPC_W];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];
  assign cls = op_class(op);
  assign alu = op_alu(op);
  // Low immediate bits go to the datapath via c_out, not to the sequencer.
  assign unused_ir = ^ir[14:0];

`ifdef CU_MEM_WAIT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  logic          mem_step;
  logic [CW-1:0] wait_q, wait_d;
  logic          fault_q, fault_d;

  assign mem_step = run_q && ((state_q == ST_T1) ||
                              (state_q == ST_T6 && cls == CLS_LD) ||
                              (state_q == ST_T7 && cls == CLS_ST));
  assign mem_go   = mem_ready;
  assign timeout  = mem_step && !mem_ready && (wait_q == WAIT_LAST);

  // Count stalled cycles of the current memory step; zero outside one.
  always_comb begin
    wait_d  = '0;
    fault_d = fault_q | timeout;
    if (mem_step && !mem_ready) wait_d = wait_q + 1'b1;
  end

  // Wait counter and sticky fault flag.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic unused_mem;

  assign mem_go     = 1'b1;
  assign timeout    = 1'b0;
  assign fault      = 1'b0;
  assign unused_mem = ^{mem_ready, 32'(WAIT_MAX)};
`endif

  // Step register; run_q stays low for the first edge so T0 starts one
  // cycle after clear releases.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_T0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Strobes and next step from (step, instruction class).
  always_comb begin
    ctl      = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_fld = rb;
    state_d  = state_q;
    case (state_q)
      ST_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.zlo_in = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
        if (mem_go) state_d = ST_T2;
      end
      ST_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        case (cls)
          CLS_ALU, CLS_IMM, CLS_LD, CLS_ST: begin
            rout_en = 1'b1; ctl.y_in = 1'b1;
          end
          CLS_UN: begin
            rout_en = 1'b1; ctl.alu_op = alu; ctl.zlo_in = 1'b1;
          end
          CLS_MD: begin
            rout_en = 1'b1; rout_fld = ra; ctl.y_in = 1'b1;
          end
          CLS_MFHI: begin
            ctl.hi_out = 1'b1; rin_en = 1'b1; state_d = ST_T0;
          end
          CLS_MFLO: begin
            ctl.lo_out = 1'b1; rin_en = 1'b1; state_d = ST_T0;
          end
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_T0;
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (cls)
          CLS_ALU: begin
            rout_en = 1'b1; rout_fld = rc; ctl.alu_op = alu; ctl.zlo_in = 1'b1;
          end
          CLS_IMM, CLS_LD, CLS_ST: begin
            ctl.c_out = 1'b1; ctl.alu_op = alu; ctl.zlo_in = 1'b1;
          end
          CLS_UN: begin
            ctl.zlo_out = 1'b1; rin_en = 1'b1; state_d = ST_T0;
          end
          CLS_MD: begin
            rout_en = 1'b1; ctl.alu_op = alu; ctl.zhi_in = 1'b1; ctl.zlo_in = 1'b1;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        state_d = ST_T6;
        case (cls)
          CLS_ALU, CLS_IMM: begin
            ctl.zlo_out = 1'b1; rin_en = 1'b1; state_d = ST_T0;
          end
          CLS_MD: begin
            ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctl.zlo_out = 1'b1; ctl.mar_in = 1'b1;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        state_d = ST_T0;
        case (cls)
          CLS_MD: begin
            ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1;
          end
          CLS_LD: begin
            ctl.read = 1'b1; ctl.mdr_in = 1'b1;
            state_d = mem_go ? ST_T7 : ST_T6;
          end
          CLS_ST: begin
            rout_en = 1'b1; rout_fld = ra; ctl.mdr_in = 1'b1; state_d = ST_T7;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T7: begin
        state_d = ST_T0;
        case (cls)
          CLS_LD: begin
            ctl.mdr_out = 1'b1; rin_en = 1'b1;
          end
          CLS_ST: begin
            ctl.write = 1'b1;
            if (!mem_go) state_d = ST_T7;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
    if (timeout) state_d = ST_HALT;
    // Before the first post-reset edge nothing is driven and T0 is held.
    if (!run_q) begin
      ctl     = '0;
      rin_en  = 1'b0;
      rout_en = 1'b0;
      state_d = ST_T0;
    end
  end

  reg_field_decoder #(.NREG(NREG)) u_rin_dec (
    .fld_i (ra),
    .en_i  (rin_en),
    .sel_o (rin)
  );

  reg_field_decoder #(.NREG(NREG)) u_rout_dec (
    .fld_i (rout_fld),
    .en_i  (rout_en),
    .sel_o (rout)
  );

  assign pc_in   = ctl.pc_in;
  assign ir_in   = ctl.ir_in;
  assign y_in    = ctl.y_in;
  assign zhi_in  = ctl.zhi_in;
  assign zlo_in  = ctl.zlo_in;
  assign hi_in   = ctl.hi_in;
  assign lo_in   = ctl.lo_in;
  assign mdr_in  = ctl.mdr_in;
  assign mar_in  = ctl.mar_in;
  assign inc_pc  = ctl.inc_pc;
  assign pc_out  = ctl.pc_out;
  assign zlo_out = ctl.zlo_out;
  assign zhi_out = ctl.zhi_out;
  assign mdr_out = ctl.mdr_out;
  assign hi_out  = ctl.hi_out;
  assign lo_out  = ctl.lo_out;
  assign c_out   = ctl.c_out;
  assign read    = ctl.read;
  assign write   = ctl.write;
  assign alu_op  = ctl.alu_op;
  assign run     = run_q && (state_q != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a directed vector table, a
// per-instruction reference model expanding opcodes into expected strobe
// sequences, randomized instruction streams, and hand-built abort, halt and
// (with CU_MEM_WAIT_EN) memory timeout sequences.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] rin, rout;
  logic pc_in, ir_in, y_in, zhi_in, zlo_in, hi_in, lo_in, mdr_in, mar_in, inc_pc;
  logic pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out, c_out, read, write;
  logic [4:0]  alu_op;
  logic        run, fault;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .rin(rin), .rout(rout),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .zhi_in(zhi_in), .zlo_in(zlo_in),
    .hi_in(hi_in), .lo_in(lo_in), .mdr_in(mdr_in), .mar_in(mar_in), .inc_pc(inc_pc),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
    .hi_out(hi_out), .lo_out(lo_out), .c_out(c_out), .read(read), .write(write),
    .alu_op(alu_op), .run(run), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [18:0] strb;
    logic [4:0]  alu;
    logic        run;
    logic        fault;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    obs_t        exp;
  } vec_t;

  localparam int S_PC_IN   = 1 << 18;
  localparam int S_IR_IN   = 1 << 17;
  localparam int S_Y_IN    = 1 << 16;
  localparam int S_ZHI_IN  = 1 << 15;
  localparam int S_ZLO_IN  = 1 << 14;
  localparam int S_HI_IN   = 1 << 13;
  localparam int S_LO_IN   = 1 << 12;
  localparam int S_MDR_IN  = 1 << 11;
  localparam int S_MAR_IN  = 1 << 10;
  localparam int S_INC_PC  = 1 << 9;
  localparam int S_PC_OUT  = 1 << 8;
  localparam int S_ZLO_OUT = 1 << 7;
  localparam int S_ZHI_OUT = 1 << 6;
  localparam int S_MDR_OUT = 1 << 5;
  localparam int S_HI_OUT  = 1 << 4;
  localparam int S_LO_OUT  = 1 << 3;
  localparam int S_C_OUT   = 1 << 2;
  localparam int S_READ    = 1 << 1;
  localparam int S_WRITE   = 1;

  localparam int A_ADD = 3;
  localparam int A_AND = 5;
  localparam int A_OR  = 6;

  localparam obs_t OBS_IDLE = '0;

  obs_t act;
  assign act = {rin, rout, pc_in, ir_in, y_in, zhi_in, zlo_in, hi_in, lo_in, mdr_in,
                mar_in, inc_pc, pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out,
                c_out, read, write, alu_op, run, fault};

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];
  vec_t dir_tab[6];

  task automatic check(input obs_t e, input string tag);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, act, e);
    end
  endtask

  function automatic obs_t mk(input logic [15:0] rin_v, input logic [15:0] rout_v,
                              input int s, input int alu_v);
    obs_t o;
    o.rin   = rin_v;
    o.rout  = rout_v;
    o.strb  = 19'(s);
    o.alu   = 5'(alu_v);
    o.run   = 1'b1;
    o.fault = 1'b0;
    return o;
  endfunction

  function automatic vec_t rec(input logic [31:0] ir_v, input logic rdy, input int s,
                               input int ri, input int ro, input int alu_v);
    vec_t v;
    v.ir  = ir_v;
    v.rdy = rdy;
    v.exp = mk((ri < 0) ? 16'h0 : (16'h1 << ri), (ro < 0) ? 16'h0 : (16'h1 << ro), s, alu_v);
    return v;
  endfunction

  function automatic vec_t halted(input logic flt);
    vec_t v;
    v.ir        = $urandom();
    v.rdy       = 1'($urandom_range(0, 1));
    v.exp       = '0;
    v.exp.fault = flt;
    return v;
  endfunction

  // One memory step: d cycles with the ready pulse on the last one when
  // waiting is enabled, otherwise exactly one cycle with ready ignored.
  task automatic push_mem(input logic [31:0] ir_v, input int d, input int s, input int ro);
`ifdef CU_MEM_WAIT_EN
    for (int i = 0; i < d; i++) vq.push_back(rec(ir_v, (i == d - 1), s, -1, ro, 0));
`else
    vq.push_back(rec(ir_v, 1'($urandom_range(0, 1)), s, -1, ro, 0));
    if (d < 0) vq.push_back(rec(ir_v, 1'b0, s, -1, ro, 0));
`endif
  endtask

  // Reference model: expected strobe sequence of one instruction.
  task automatic model_instr(input logic [31:0] iv, input int d1, input int d6);
    logic [31:0] junk;
    int op, ra, rb, rc, alu_v;
    junk = $urandom();
    op = int'(iv[31:27]);
    ra = int'(iv[26:23]);
    rb = int'(iv[22:19]);
    rc = int'(iv[18:15]);
    vq.push_back(rec(junk, 1'($urandom_range(0, 1)), S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLO_IN, -1, -1, 0));
    push_mem(junk, d1, S_ZLO_OUT | S_PC_IN | S_READ | S_MDR_IN, -1);
    vq.push_back(rec(junk, 1'($urandom_range(0, 1)), S_MDR_OUT | S_IR_IN, -1, -1, 0));
    case (op)
      3, 4, 5, 6, 7, 8, 9, 10, 11: begin
        vq.push_back(rec(iv, 1'b0, S_Y_IN, -1, rb, 0));
        vq.push_back(rec(iv, 1'b1, S_ZLO_IN, -1, rc, op));
        vq.push_back(rec(iv, 1'b0, S_ZLO_OUT, ra, -1, 0));
      end
      1, 12, 13, 14: begin
        alu_v = (op == 13) ? A_AND : (op == 14) ? A_OR : A_ADD;
        vq.push_back(rec(iv, 1'b1, S_Y_IN, -1, rb, 0));
        vq.push_back(rec(iv, 1'b0, S_C_OUT | S_ZLO_IN, -1, -1, alu_v));
        vq.push_back(rec(iv, 1'b1, S_ZLO_OUT, ra, -1, 0));
      end
      17, 18: begin
        vq.push_back(rec(iv, 1'b0, S_ZLO_IN, -1, rb, op));
        vq.push_back(rec(iv, 1'b1, S_ZLO_OUT, ra, -1, 0));
      end
      15, 16: begin
        vq.push_back(rec(iv, 1'b1, S_Y_IN, -1, ra, 0));
        vq.push_back(rec(iv, 1'b0, S_ZHI_IN | S_ZLO_IN, -1, rb, op));
        vq.push_back(rec(iv, 1'b1, S_ZLO_OUT | S_LO_IN, -1, -1, 0));
        vq.push_back(rec(iv, 1'b0, S_ZHI_OUT | S_HI_IN, -1, -1, 0));
      end
      0, 2: begin
        vq.push_back(rec(iv, 1'b0, S_Y_IN, -1, rb, 0));
        vq.push_back(rec(iv, 1'b1, S_C_OUT | S_ZLO_IN, -1, -1, A_ADD));
        vq.push_back(rec(iv, 1'b0, S_ZLO_OUT | S_MAR_IN, -1, -1, 0));
        if (op == 0) begin
          push_mem(iv, d6, S_READ | S_MDR_IN, -1);
          vq.push_back(rec(iv, 1'b0, S_MDR_OUT, ra, -1, 0));
        end else begin
          vq.push_back(rec(iv, 1'b1, S_MDR_IN, -1, ra, 0));
          push_mem(iv, d6, S_WRITE, -1);
        end
      end
      24: vq.push_back(rec(iv, 1'b0, S_HI_OUT, ra, -1, 0));
      25: vq.push_back(rec(iv, 1'b1, S_LO_OUT, ra, -1, 0));
      default: vq.push_back(rec(iv, 1'($urandom_range(0, 1)), 0, -1, -1, 0));
    endcase
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(posedge clock);
    #1;
    ir        = v.ir;
    mem_ready = v.rdy;
    @(negedge clock);
    check(v.exp, tag);
  endtask

  task automatic drain(input string tag);
    while (vq.size() > 0) apply(vq.pop_front(), tag);
  endtask

  // Asynchronous clear pulse from mid-cycle, then release.
  task automatic do_clear(input string tag);
    #2 clear = 1'b0;
    #1 check(OBS_IDLE, {tag, "_async"});
    @(posedge clock);
    #1 check(OBS_IDLE, {tag, "_held"});
    clear = 1'b1;
    @(negedge clock);
    check(OBS_IDLE, {tag, "_rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] riv;
    int          rop;

    dir_tab[0] = '{32'h0, 1'b1, mk(16'h0, 16'h0, S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLO_IN, 0)};
    dir_tab[1] = '{32'h0, 1'b1, mk(16'h0, 16'h0, S_ZLO_OUT | S_PC_IN | S_READ | S_MDR_IN, 0)};
    dir_tab[2] = '{32'h0, 1'b0, mk(16'h0, 16'h0, S_MDR_OUT | S_IR_IN, 0)};
    dir_tab[3] = '{32'h18918000, 1'b0, mk(16'h0, 16'h0004, S_Y_IN, 0)};
    dir_tab[4] = '{32'h18918000, 1'b0, mk(16'h0, 16'h0008, S_ZLO_IN, 5'b00011)};
    dir_tab[5] = '{32'h18918000, 1'b0, mk(16'h0002, 16'h0, S_ZLO_OUT, 0)};

    clear     = 1'b0;
    ir        = 32'h0;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check(OBS_IDLE, "reset");
    end
    @(posedge clock);
    #1 clear = 1'b1;
    @(negedge clock);
    check(OBS_IDLE, "reset_rel");

    for (int i = 0; i < 6; i++) apply(dir_tab[i], "add_dir");

    model_instr(32'h02100010, 1, 3);
    drain("ld");
    model_instr(32'hC2800000, 2, 1);
    drain("mfhi");

    for (int n = 0; n < 60; n++) begin
      riv = $urandom();
      rop = $urandom_range(0, 31);
      if (rop == 27) rop = 26;
      riv[31:27] = 5'(rop);
      model_instr(riv, $urandom_range(1, 4), $urandom_range(1, 4));
      drain("rand");
    end

    // Clear in the middle of an add (T4) must kill every strobe at once.
    model_instr(32'h18918000, 1, 1);
    for (int i = 0; i < 5; i++) apply(vq.pop_front(), "abort_pre");
    vq.delete();
    do_clear("abort");
    model_instr(32'h18918000, 1, 1);
    drain("abort_restart");

    model_instr(32'hD8000000, 1, 1);
    repeat (20) vq.push_back(halted(1'b0));
    drain("halt");
    do_clear("halt_clr");
    model_instr(32'hC9000000, 1, 1);
    drain("halt_restart");

`ifdef CU_MEM_WAIT_EN
    // Instruction fetch never sees mem_ready: halt with fault after 15 cycles.
    vq.push_back(rec(32'h0, 1'b0, S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLO_IN, -1, -1, 0));
    repeat (15) vq.push_back(rec(32'h0, 1'b0, S_ZLO_OUT | S_PC_IN | S_READ | S_MDR_IN, -1, -1, 0));
    repeat (5) vq.push_back(halted(1'b1));
    drain("timeout");
    do_clear("timeout_clr");
    model_instr(32'h18918000, 2, 1);
    drain("timeout_restart");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
